// File: rtl/vector_checker.sv
`default_nettype none
// ============================================================================
// Module      : vector_checker
// Description : Stimulus/response sequencer that drives stored vectors into a
//               device under verification and compares its responses.
//               Optional macro VECCHK_STOP_ON_ERR_EN ends a run on the first
//               mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_checker #(
    parameter int SW    = 34,
    parameter int RW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              vec_we,
    input  logic [AW-1:0]     vec_waddr,
    input  logic [SW+RW:0]    vec_wdata,
    output logic [SW-1:0]     duv_stim,
    input  logic [RW-1:0]     duv_resp,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [AW:0]       test_count,
    output logic [AW:0]       err_count,
    output logic [AW-1:0]     first_err
);

    localparam int               c_EW        = 1 + SW + RW;
    localparam int               c_CW        = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [c_CW-1:0]  c_WAIT_LAST = c_CW'(LAT - 1);
    localparam logic [c_CW-1:0]  c_WAIT_ONE  = c_CW'(1);
    localparam logic [AW-1:0]    c_IDX_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0]    c_IDX_ONE   = AW'(1);
    localparam logic [AW:0]      c_CNT_ONE   = (AW+1)'(1);
`ifdef VECCHK_STOP_ON_ERR_EN
    localparam logic             c_STOP_ON_ERR = 1'b1;
`else
    localparam logic             c_STOP_ON_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [c_EW-1:0] r_mem [DEPTH];

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_idx,   w_idx_nxt;
    logic [c_CW-1:0] r_wait,  w_wait_nxt;
    logic [SW-1:0]   r_stim,  w_stim_nxt;
    logic [AW:0]     r_test,  w_test_nxt;
    logic [AW:0]     r_err,   w_err_nxt;
    logic [AW-1:0]   r_first, w_first_nxt;
    logic            r_mis,   w_mis_nxt;

    logic            w_busy;
    logic [AW-1:0]   w_idx_inc;
    logic            w_first_valid;
    logic            w_nxt_valid;
    logic            w_miscompare;

    assign w_busy = (r_state == S_APPLY) || (r_state == S_CHECK);

    // Table is frozen during a run; contents survive reset.
    always_ff @(posedge clk) begin
        if (vec_we && !w_busy) begin
            r_mem[vec_waddr] <= vec_wdata;
        end
    end

    assign w_idx_inc     = r_idx + c_IDX_ONE;
    assign w_first_valid = r_mem[0][c_EW-1];
    assign w_nxt_valid   = (r_idx != c_IDX_LAST) && r_mem[w_idx_inc][c_EW-1];
    assign w_miscompare  = (duv_resp != r_mem[r_idx][RW-1:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_wait  <= '0;
            r_stim  <= '0;
            r_test  <= '0;
            r_err   <= '0;
            r_first <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_wait  <= w_wait_nxt;
            r_stim  <= w_stim_nxt;
            r_test  <= w_test_nxt;
            r_err   <= w_err_nxt;
            r_first <= w_first_nxt;
            r_mis   <= w_mis_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wait_nxt  = r_wait;
        w_stim_nxt  = r_stim;
        w_test_nxt  = r_test;
        w_err_nxt   = r_err;
        w_first_nxt = r_first;
        w_mis_nxt   = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_idx_nxt   = '0;
                    w_wait_nxt  = '0;
                    w_test_nxt  = '0;
                    w_err_nxt   = '0;
                    w_first_nxt = '0;
                    if (w_first_valid) begin
                        w_state_nxt = S_APPLY;
                        w_stim_nxt  = r_mem[0][SW+RW-1:RW];
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_APPLY: begin
                if (r_wait == c_WAIT_LAST) begin
                    w_state_nxt = S_CHECK;
                    w_wait_nxt  = '0;
                end else begin
                    w_wait_nxt  = r_wait + c_WAIT_ONE;
                end
            end
            S_CHECK: begin
                w_test_nxt = r_test + c_CNT_ONE;
                if (w_miscompare) begin
                    w_err_nxt = r_err + c_CNT_ONE;
                    w_mis_nxt = 1'b1;
                    if (r_err == '0) begin
                        w_first_nxt = r_idx;
                    end
                end
                // Last entry or sentinel ends the run; idx never wraps.
                if ((w_miscompare && c_STOP_ON_ERR) || !w_nxt_valid) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_APPLY;
                    w_idx_nxt   = w_idx_inc;
                    w_stim_nxt  = r_mem[w_idx_inc][SW+RW-1:RW];
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign duv_stim   = r_stim;
    assign busy       = w_busy;
    assign done       = (r_state == S_DONE);
    assign mismatch   = r_mis;
    assign test_count = r_test;
    assign err_count  = r_err;
    assign first_err  = r_first;

endmodule
`default_nettype wire

// File: doc/vector_checker.md
# vector_checker

Hardware stimulus/response sequencer for on-board verification of MIPS datapath blocks (flopr, ALU, register file). It is the in-silicon counterpart of our software testbenches. It holds a vector table loaded through a write port, drives each vector's stimulus into a device under verification (DUV), and compares the DUV response against the stored expected value. It reports the number of tests run, the mismatch count and the index of the first failure.

## Interface

Parameters:
- `SW`, default 34: stimulus width in bits (e.g. {clk_in, rst_in, d[31:0]}).
- `RW`, default 32: response width in bits.
- `DEPTH`, default 16: number of vector entries.
- `AW`, default 4: address width, equal to clog2(DEPTH).
- `LAT`, default 1: DUV settle cycles, ≥1.

Ports (clock and reset first):
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin a run; single-cycle pulse or level.
- `vec_we`, in, 1: vector table write enable.
- `vec_waddr`, in, AW: vector table write address.
- `vec_wdata`, in, 1+SW+RW: vector entry, packed as {valid, stim[SW-1:0], exp[RW-1:0]}.
- `duv_stim`, out, SW: stimulus driven to the DUV.
- `duv_resp`, in, RW: DUV response.
- `busy`, out, 1: high while a run is in progress.
- `done`, out, 1: high from the end of a run until the next start or reset.
- `mismatch`, out, 1: one-cycle pulse on each failing compare.
- `test_count`, out, AW+1: number of vectors checked in the current run.
- `err_count`, out, AW+1: number of mismatches in the current run.
- `first_err`, out, AW: index of the first failing vector; valid when err_count≠0.

## Operation

- Vector table: DEPTH×(1+SW+RW) register array with asynchronous read.
  - Writes occur only in IDLE or DONE. `vec_we` is ignored while `busy` is high.
  - Table contents are not cleared by reset.
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE: `busy`=0, `done`=0. When `start`=1:
  - idx←0; test_count, err_count and first_err←0.
  - Go to APPLY if mem[0].valid=1.
  - Go to DONE if mem[0].valid=0 (empty table); test_count stays 0.
- APPLY: `duv_stim`=mem[idx].stim. A wait counter runs LAT cycles, then the FSM goes to CHECK.
- CHECK: `duv_stim` is held. At the clock edge leaving CHECK, `duv_resp` is compared with mem[idx].exp.
  - Comparison is bitwise equality over RW bits.
  - test_count is incremented.
  - On a mismatch: err_count is incremented, `mismatch` pulses for the following cycle, and first_err←idx if err_count was 0.
  - Next state:
    - DONE if idx=DEPTH-1 or mem[idx+1].valid=0 (sentinel).
    - Otherwise idx←idx+1 and APPLY.
- DONE: `done`=1, `busy`=0, and all counters hold.
  - `start` in DONE behaves exactly as in IDLE and restarts the run.
  - Otherwise the FSM stays in DONE.
- `start` while `busy`=1 is ignored.
- idx never wraps. A full table ends at DEPTH-1 without a sentinel.
- Counters are AW+1 bits wide, so the maximum value DEPTH never overflows.

## Timing

- Reset (rst=0 at a rising edge): state←IDLE. The following outputs go to 0: `duv_stim`, `busy`, `done`, `mismatch`, `test_count`, `err_count`, `first_err`.
  - Reset mid-run aborts the run immediately, with no final compare.
- Start to first stimulus: `start` is sampled at edge N. `duv_stim`=vector 0 and `busy`=1 from edge N.
- Per-vector period: LAT+1 cycles.
  - The response is sampled LAT+1 edges after the stimulus changes.
  - This covers a registered DUV with 1-cycle latency.
- Timing of result outputs relative to the final CHECK edge:
  - `done` rises on that edge.
  - `busy` falls on the same edge.
  - `mismatch` and the counter updates become visible on the same edge.
- Full-table run time: DEPTH×(LAT+1) cycles from start to done.

## Configuration

Macro `VECCHK_STOP_ON_ERR_EN`:
- Defined: the first mismatch ends the run. CHECK goes directly to DONE, so err_count=1 and test_count equals the failing index+1.
- Undefined (default): every valid vector is checked regardless of mismatches.

## Test plan

1. Reset with no start; load three valid vectors and a sentinel; start with a flopr DUV whose responses all match → done after 6 cycles, test_count=3, err_count=0, no `mismatch` pulse.
2. Force duv_resp to 0x00000000 against exp 0xDEADBEEF at vector 1 of 3 → err_count=1, first_err=1, one `mismatch` pulse, test_count=3.
3. Fill all 16 entries as valid, with no sentinel → done after 32 cycles, test_count=16, idx does not wrap.
4. Sentinel at entry 0 → done on the cycle after start, test_count=0, `busy` never asserted.
5. Assert rst=0 mid-run at vector 2; attempt `vec_we` during the run; pulse `start` while busy → reset clears all outputs, the blocked write leaves the table unchanged, and the second start has no effect.
6. With `VECCHK_STOP_ON_ERR_EN` defined, mismatches at vectors 1 and 3 → done after vector 1, err_count=1, test_count=2, first_err=1.
